int8_vecmac_stream: RTL and testbench

Streaming INT8 dot-product engine with a parametrised number of lanes. It replaces the fixed-length, fixed-lane vector MAC. It accepts a run-time element count and signed or unsigned operands, and it masks the unused lanes of a partial final beat. Valid/ready handshakes on both sides let it sit between a DMA/stream source and a result FIFO that can stall.

---
 rtl/int8_vecmac_pkg.sv | 13 +
 rtl/int8_vecmac_lane_mul.sv | 45 ++++
 rtl/int8_vecmac_stream.sv | 88 ++++++++
 tb/tb_int8_vecmac_stream.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int8_vecmac_pkg.sv
// int8_vecmac_pkg: shared state encoding, widths and helpers for the INT8 vector MAC.
package int8_vecmac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_e;
  localparam int PROD_W = 16;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int beats_from_len(input int len, input int lanes);
    return (len + lanes - 1) / lanes;
  endfunction
endpackage

// File: rtl/int8_vecmac_lane_mul.sv
// int8_vecmac_lane_mul: per-lane 8x8 multipliers, lane masking and adder tree, registered beat sum.
module int8_vecmac_lane_mul
  import int8_vecmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 signed_i,
  input  logic [LANES-1:0]     mask_i,
  input  logic [8*LANES-1:0]   a_i,
  input  logic [8*LANES-1:0]   b_i,
  output logic [ACC_W-1:0]     sum_o,
  output logic                 vld_o
);
  localparam int XW = PROD_W + 2;
  logic signed [XW-1:0] xa, xb, p;
  logic [ACC_W-1:0] sum_d, sum_q;
  logic vld_q;
  // 9-bit operands carry the mode: sign bit copied when signed, zero otherwise
  always_comb begin
    sum_d = '0;
    xa = '0;
    xb = '0;
    p = '0;
    for (int i = 0; i < LANES; i++) begin
      xa = XW'($signed({signed_i & a_i[8*i+7], a_i[8*i +: 8]}));
      xb = XW'($signed({signed_i & b_i[8*i+7], b_i[8*i +: 8]}));
      p = xa * xb;
      sum_d = sum_d + (mask_i[i] ? ACC_W'(p) : '0);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) sum_q <= sum_d;
    end
  assign sum_o = sum_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/int8_vecmac_stream.sv
// int8_vecmac_stream: streaming INT8 dot product with run-time length and signedness.
// Define INT8_VECMAC_SATURATE_EN for a clamping accumulator; otherwise it wraps.
module int8_vecmac_stream
  import int8_vecmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_signed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_a,
  input  logic [8*LANES-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
  output logic               busy
);
  localparam int CW = clog2(LANES + 1);
  state_e state_q, state_d;
  logic [LEN_W-1:0] beats_q;
  logic [LANES-1:0] last_mask_q, last_mask_d, mask;
  logic [CW-1:0] rem;
  logic [ACC_W-1:0] acc_q, acc_nxt, beat_sum, add;
  logic sgn_q, ovf_q, acc_en, p_vld, carry, ovf_now;
  assign in_ready = state_q == RUN;
  assign out_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign out_sum = acc_q;
  assign out_ovf = ovf_q;
  assign acc_en = in_valid & in_ready;
  assign rem = CW'(cfg_len % LEN_W'(LANES));
  assign mask = beats_q == LEN_W'(1) ? last_mask_q : '1;
  always_comb begin
    last_mask_d = '0;
    for (int i = 0; i < LANES; i++) last_mask_d[i] = rem == '0 || CW'(i) < rem;
  end
  always_comb
    state_d = state_q == IDLE  ? (start ? (cfg_len == '0 ? HOLD : RUN) : IDLE)
            : state_q == RUN   ? (acc_en && beats_q == LEN_W'(1) ? DRAIN : RUN)
            : state_q == DRAIN ? HOLD
            : out_ready        ? IDLE : HOLD;
  int8_vecmac_lane_mul #(.LANES(LANES), .ACC_W(ACC_W)) u_mul (
    .clk(clk), .rst(rst), .en_i(acc_en), .signed_i(sgn_q), .mask_i(mask),
    .a_i(in_a), .b_i(in_b), .sum_o(beat_sum), .vld_o(p_vld)
  );
  always_comb begin
    {carry, add} = {1'b0, acc_q} + {1'b0, beat_sum};
    ovf_now = sgn_q ? (acc_q[ACC_W-1] == beat_sum[ACC_W-1] && add[ACC_W-1] != acc_q[ACC_W-1]) : carry;
  end
`ifdef INT8_VECMAC_SATURATE_EN
  logic [ACC_W-1:0] sat_val;
  assign sat_val = !sgn_q ? '1 : acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign acc_nxt = ovf_q ? acc_q : ovf_now ? sat_val : add;
`else
  assign acc_nxt = add;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      beats_q <= '0;
      last_mask_q <= '0;
      sgn_q <= 1'b0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        beats_q <= LEN_W'(beats_from_len(int'(cfg_len), LANES));
        last_mask_q <= last_mask_d;
        sgn_q <= cfg_signed;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (acc_en) beats_q <= beats_q - 1'b1;
        if (p_vld) begin
          acc_q <= acc_nxt;
          ovf_q <= ovf_q | ovf_now;
        end
      end
    end
endmodule

// File: tb/tb_int8_vecmac_stream.sv
// tb_int8_vecmac_stream: randomized bench for int8_vecmac_stream against a per-beat arithmetic model.
module tb_int8_vecmac_stream;
  logic clk = 0, rst = 1;
  logic start = 0, cfg_signed = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [15:0] cfg_len = '0;
  logic [31:0] in_a = '0, in_b = '0, out_sum;
  logic s_start = 0, s_signed = 0, s_in_valid = 0, s_out_ready = 0;
  logic s_in_ready, s_out_valid, s_out_ovf, s_busy;
  logic [15:0] s_len = '0, s_sum;
  logic [7:0] s_a = '0, s_b = '0;
  int va [0:1023];
  int vb [0:1023];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  int8_vecmac_stream #(.LANES(4), .ACC_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );
  int8_vecmac_stream #(.LANES(1), .ACC_W(16), .LEN_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .cfg_len(s_len), .cfg_signed(s_signed),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_a), .in_b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_sum), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  function automatic longint sx(input int v, input bit s);
    return (s && v > 127) ? longint'(v - 256) : longint'(v);
  endfunction

  // Dot product over the element arrays, accumulated one beat of `lanes` elements at a time
  function automatic void model(input int len, input bit sgn, input int w, input int lanes,
                                output longint res, output bit ovf);
    longint acc, bs, t, lo, hi, m;
    bit frz;
    m = longint'(1) << w;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? m / 2 - 1 : m - 1;
    acc = 0; ovf = 0; frz = 0;
    for (int k = 0; k < len; k += lanes) begin
      bs = 0;
      for (int j = k; j < k + lanes && j < len; j++) bs += sx(va[j], sgn) * sx(vb[j], sgn);
      t = acc + bs;
      if (t < lo || t > hi) begin
        ovf = 1;
`ifdef INT8_VECMAC_SATURATE_EN
        if (!frz) acc = t < lo ? lo : hi;
        frz = 1;
`else
        t = (t - lo) % m;
        if (t < 0) t += m;
        acc = t + lo;
`endif
      end else if (!frz) acc = t;
    end
    res = acc;
  endfunction

  task automatic fill_rand();
    for (int j = 0; j < 1024; j++) begin
      va[j] = int'($urandom_range(255));
      vb[j] = int'($urandom_range(255));
    end
  endtask

  // Drives one vector into the 4-lane DUT; lat = cycles from the last accept (or start) to out_valid
  task automatic run_vec(input int len, input bit sgn, input int gap, input bit poke,
                         output logic [31:0] s, output logic o, output int lat);
    int nb, b, k;
    nb = (len + 3) / 4; b = 0; k = 0;
    @(negedge clk); start = 1; cfg_len = 16'(len); cfg_signed = sgn;
    @(negedge clk); start = poke; cfg_len = 16'($urandom_range(1, 200)); cfg_signed = ~sgn;
    while (b < nb && k < 20000) begin
      in_valid = (gap == 0) || ($urandom_range(99) >= gap);
      for (int l = 0; l < 4; l++) begin
        in_a[8*l +: 8] = 8'(va[4*b+l]);
        in_b[8*l +: 8] = 8'(vb[4*b+l]);
      end
      if (in_valid && in_ready) b++;
      @(negedge clk); k++;
    end
    in_valid = 1; in_a = $urandom; in_b = $urandom;
    k = 1;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    lat = (out_valid && b == nb) ? k : -1;
    in_valid = 0; start = 0;
    s = out_sum; o = out_ovf;
  endtask

  task automatic consume();
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic run16(input int len, input bit sgn, output logic [15:0] s, output logic o, output int lat);
    int b, k;
    b = 0; k = 0;
    @(negedge clk); s_start = 1; s_len = 16'(len); s_signed = sgn;
    @(negedge clk); s_start = 0; s_in_valid = 1;
    while (b < len && k < 200) begin
      s_a = 8'(va[b]); s_b = 8'(vb[b]);
      if (s_in_ready) b++;
      @(negedge clk); k++;
    end
    s_in_valid = 0;
    k = 1;
    while (!s_out_valid && k < 20) begin @(negedge clk); k++; end
    lat = (s_out_valid && b == len) ? k : -1;
    s = s_sum; o = s_out_ovf;
    s_out_ready = 1; @(negedge clk); s_out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    n_cmp += 6;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_sum !== 32'h0) begin n_bad++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
    if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid16 got %b want 0", s_out_valid); end
  endtask

  task automatic test_unsigned_ff();
    logic [31:0] s; logic o; int lat;
    for (int j = 0; j < 1024; j++) begin va[j] = 255; vb[j] = 255; end
    run_vec(1000, 0, 0, 0, s, o, lat);
    n_cmp += 3;
    if (s !== 32'h03E033E8) begin n_bad++; $display("FAIL ff1000_sum got %h want 03e033e8", s); end
    if (o !== 1'b0) begin n_bad++; $display("FAIL ff1000_ovf got %b want 0", o); end
    if (lat != 2) begin n_bad++; $display("FAIL ff1000_latency got %0d want 2", lat); end
    consume();
  endtask

  task automatic test_signed();
    logic [31:0] s; logic o; int lat;
    fill_rand();
    for (int j = 0; j < 3; j++) begin va[j] = 'h80; vb[j] = 'h7F; end
    run_vec(3, 1, 0, 0, s, o, lat);
    n_cmp += 2;
    if (s !== 32'hFFFF4180) begin n_bad++; $display("FAIL signed3_sum got %h want ffff4180", s); end
    if (o !== 1'b0) begin n_bad++; $display("FAIL signed3_ovf got %b want 0", o); end
    consume();
    for (int j = 0; j < 10; j++) begin va[j] = 'h80; vb[j] = 'h80; end
    run_vec(10, 1, 0, 0, s, o, lat);
    n_cmp += 2;
    if (s !== 32'h00028000) begin n_bad++; $display("FAIL signed10_sum got %h want 00028000", s); end
    if (lat != 2) begin n_bad++; $display("FAIL signed10_latency got %0d want 2", lat); end
    consume();
  endtask

  task automatic test_partial();
    logic [31:0] s; logic o; int lat;
    for (int j = 0; j < 5; j++) begin va[j] = 1; vb[j] = 1; end
    for (int j = 5; j < 8; j++) begin va[j] = 'hFF; vb[j] = 'hFF; end
    run_vec(5, 0, 0, 0, s, o, lat);
    n_cmp += 1;
    if (s !== 32'd5) begin n_bad++; $display("FAIL partial5_sum got %0d want 5", s); end
    consume();
  endtask

  task automatic test_zero_len();
    logic [31:0] s; logic o; int lat;
    for (int j = 0; j < 4; j++) begin va[j] = 9; vb[j] = 9; end
    run_vec(4, 0, 0, 0, s, o, lat);
    consume();
    run_vec(0, 0, 0, 0, s, o, lat);
    n_cmp += 3;
    if (s !== 32'h0) begin n_bad++; $display("FAIL zero_len_sum got %h want 0", s); end
    if (o !== 1'b0) begin n_bad++; $display("FAIL zero_len_ovf got %b want 0", o); end
    if (lat != 1) begin n_bad++; $display("FAIL zero_len_latency got %0d want 1", lat); end
    consume();
  endtask

  task automatic test_start_ignored();
    logic [31:0] s; logic o; int lat; longint r; bit ro;
    fill_rand();
    model(23, 1, 32, 4, r, ro);
    run_vec(23, 1, 20, 1, s, o, lat);
    n_cmp += 2;
    if (s !== 32'(r)) begin n_bad++; $display("FAIL start_in_run_sum got %h want %h", s, 32'(r)); end
    if (lat != 2) begin n_bad++; $display("FAIL start_in_run_latency got %0d want 2", lat); end
    start = 1; cfg_len = 16'd0;
    repeat (2) @(negedge clk);
    start = 0;
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL start_in_hold_valid got %b want 1", out_valid); end
    if (out_sum !== 32'(r)) begin n_bad++; $display("FAIL start_in_hold_sum got %h want %h", out_sum, 32'(r)); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] s; logic o; int lat; longint r; bit ro; int bad;
    fill_rand();
    model(20, 0, 32, 4, r, ro);
    run_vec(20, 0, 0, 0, s, o, lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1; in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 32'(r) || out_ovf !== ro || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_cycle%0d got v=%b sum=%h ovf=%b rdy=%b want v=1 sum=%h ovf=%b rdy=0",
                 c, out_valid, out_sum, out_ovf, in_ready, 32'(r), ro);
      end
    end
    in_valid = 0;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] s; logic o; int lat; longint r; bit ro;
    fill_rand();
    for (int it = 0; it < 2; it++) begin
      model(12 + it, 0, 32, 4, r, ro);
      run_vec(12 + it, 0, 0, 0, s, o, lat);
      n_cmp += 1;
      if (s !== 32'(r)) begin n_bad++; $display("FAIL b2b%0d_sum got %h want %h", it, s, 32'(r)); end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      n_cmp += 1;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL b2b%0d_release got v=%b busy=%b want 0 0", it, out_valid, busy);
      end
    end
  endtask

  task automatic test_gap_equiv();
    logic [31:0] s0, s1; logic o; int lat; longint r; bit ro;
    fill_rand();
    model(37, 1, 32, 4, r, ro);
    run_vec(37, 1, 0, 0, s0, o, lat);
    consume();
    run_vec(37, 1, 60, 0, s1, o, lat);
    consume();
    n_cmp += 2;
    if (s0 !== 32'(r)) begin n_bad++; $display("FAIL gapfree_sum got %h want %h", s0, 32'(r)); end
    if (s1 !== s0) begin n_bad++; $display("FAIL gapped_sum got %h want %h", s1, s0); end
  endtask

  task automatic test_random();
    logic [31:0] s; logic o; int lat, len; bit sgn; longint r; bit ro;
    for (int it = 0; it < 10; it++) begin
      fill_rand();
      len = int'($urandom_range(1, 64));
      sgn = 1'($urandom_range(1));
      model(len, sgn, 32, 4, r, ro);
      run_vec(len, sgn, 30, 1'($urandom_range(1)), s, o, lat);
      n_cmp += 3;
      if (s !== 32'(r)) begin n_bad++; $display("FAIL rand%0d_sum len=%0d got %h want %h", it, len, s, 32'(r)); end
      if (o !== ro) begin n_bad++; $display("FAIL rand%0d_ovf got %b want %b", it, o, ro); end
      if (lat != 2) begin n_bad++; $display("FAIL rand%0d_latency got %0d want 2", it, lat); end
      consume();
    end
  endtask

  task automatic test_acc16();
    logic [15:0] s; logic o; int lat; longint r; bit ro;
    logic [15:0] exp_u, exp_s;
`ifdef INT8_VECMAC_SATURATE_EN
    exp_u = 16'hFFFF; exp_s = 16'h7FFF;
`else
    exp_u = 16'hFC02; exp_s = 16'h8000;
`endif
    for (int j = 0; j < 2; j++) begin va[j] = 'hFF; vb[j] = 'hFF; end
    model(2, 0, 16, 1, r, ro);
    run16(2, 0, s, o, lat);
    n_cmp += 4;
    if (s !== exp_u) begin n_bad++; $display("FAIL acc16_unsigned_sum got %h want %h", s, exp_u); end
    if (s !== 16'(r)) begin n_bad++; $display("FAIL acc16_unsigned_model got %h want %h", s, 16'(r)); end
    if (o !== 1'b1) begin n_bad++; $display("FAIL acc16_unsigned_ovf got %b want 1", o); end
    if (lat != 2) begin n_bad++; $display("FAIL acc16_latency got %0d want 2", lat); end
    for (int j = 0; j < 3; j++) begin va[j] = 'h80; vb[j] = 'h80; end
    run16(2, 1, s, o, lat);
    n_cmp += 2;
    if (s !== exp_s) begin n_bad++; $display("FAIL acc16_signed_sum got %h want %h", s, exp_s); end
    if (o !== 1'b1) begin n_bad++; $display("FAIL acc16_signed_ovf got %b want 1", o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic o; int lat, seen; longint r; bit ro;
    fill_rand();
    @(negedge clk); start = 1; cfg_len = 16'd40; cfg_signed = 0;
    @(negedge clk); start = 0; in_valid = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      in_a = $urandom; in_b = $urandom;
      if (out_valid || busy) seen++;
      @(negedge clk);
    end
    in_valid = 0;
    n_cmp += 1;
    if (seen != 0) begin n_bad++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen); end
    model(17, 1, 32, 4, r, ro);
    run_vec(17, 1, 0, 0, s, o, lat);
    n_cmp += 2;
    if (s !== 32'(r)) begin n_bad++; $display("FAIL rst_mid_next_sum got %h want %h", s, 32'(r)); end
    if (lat != 2) begin n_bad++; $display("FAIL rst_mid_next_latency got %0d want 2", lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_unsigned_ff();
    test_signed();
    test_partial();
    test_zero_len();
    test_start_ignored();
    test_backpressure();
    test_back_to_back();
    test_gap_equiv();
    test_random();
    test_acc16();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
